// File: rtl/cache_arb_pkg.sv
// cache_arb_pkg: shared types and constants for the cache port arbiter.
//   arbState_t : FSM state encoding (S_IDLE=0, S_ISSUE=1, S_WAIT=2)
//   AW_DEF/W_DEF : default word-address and data widths
//   ID_W : width of a requester ID (two requesters)
//   SETTLE_W : width of the post-strobe settle counter (SETTLE_CYC <= 3)
package cache_arb_pkg;

    localparam int AW_DEF   = 10;
    localparam int W_DEF    = 32;
    localparam int ID_W     = 1;
    localparam int SETTLE_W = 2;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2
    } arbState_t;

endpackage

// File: rtl/cache_port_arbiter_rr_pick2.sv
// rr_pick2: combinational two-way picker.
//   req[1:0]    : pending requests
//   lastGnt     : requester that won the previous arbitration
//   winner[1:0] : one-hot winner, 2'b00 when nothing is requested
// Build option CACHE_ARB_RR_EN: defined -> round-robin (the requester that is
// not lastGnt wins a tie); undefined -> fixed priority, requester 0 wins.
module rr_pick2 (
    input  logic       [1:0] req,
    input  logic             lastGnt,
    output logic       [1:0] winner
);

`ifdef CACHE_ARB_RR_EN
    always_comb begin
        winner = 2'b00;
        if (req == 2'b11) begin
            winner = lastGnt ? 2'b01 : 2'b10;
        end else begin
            winner = req;
        end
    end
`else
    // Fixed priority has no use for the round-robin pointer.
    logic unusedLastGnt;
    assign unusedLastGnt = lastGnt;

    always_comb begin
        winner = 2'b00;
        if (req[0]) begin
            winner = 2'b01;
        end else if (req[1]) begin
            winner = 2'b10;
        end
    end
`endif

endmodule

// File: rtl/cache_port_arbiter.sv
// cache_port_arbiter: two-requester arbiter/sequencer in front of the
// write-through cache. One transaction at a time: accept (IDLE), pulse gnt and
// a single mem_read/mem_write strobe (ISSUE), then hold address/data until the
// cache stops stalling and return completion (WAIT).
// Ports:
//   clk, reset (async, active low)
//   req/req_we/req_addr/req_wdata : requester side, requester i at slice i
//   gnt, rsp_valid, rsp_rdata      : one-cycle grant / completion pulses, read data
//   busy                           : FSM not in IDLE
//   cache_addr/cache_wdata/cache_rd/cache_wr : to WordAddress/DataIn/mem_read/mem_write
//   cache_stall/cache_rdata        : from stall/DataOut
// Handshake: a requester holds req until it sees gnt; gnt and rsp_valid are
// single-cycle pulses; rsp_rdata is meaningful only while rsp_valid is high.
// Build option CACHE_ARB_RR_EN selects round-robin (defined) or fixed
// priority (undefined) arbitration.
// All outputs are registered so nothing toward the cache can glitch.
module cache_port_arbiter
    import cache_arb_pkg::*;
#(
    parameter int AW         = AW_DEF,
    parameter int W          = W_DEF,
    parameter int SETTLE_CYC = 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [1:0]      req,
    input  logic [1:0]      req_we,
    input  logic [2*AW-1:0] req_addr,
    input  logic [2*W-1:0]  req_wdata,
    output logic [1:0]      gnt,
    output logic [1:0]      rsp_valid,
    output logic [W-1:0]    rsp_rdata,
    output logic            busy,
    output logic [AW-1:0]   cache_addr,
    output logic [W-1:0]    cache_wdata,
    output logic            cache_rd,
    output logic            cache_wr,
    input  logic            cache_stall,
    input  logic [W-1:0]    cache_rdata
);

    arbState_t           state, stateNext;
    logic [ID_W-1:0]     owner, ownerNext;
    logic                ownerWe, ownerWeNext;
    logic [SETTLE_W-1:0] settleCnt, settleNext;
    logic                lastGnt;
    logic [1:0]          winner;
    logic [ID_W-1:0]     winnerId;

    logic [1:0]          gntNext, rspValidNext;
    logic [W-1:0]        rspRdataNext, wdataNext;
    logic [AW-1:0]       addrNext;
    logic                rdNext, wrNext, busyNext;

    rr_pick2 uPick (
        .req     (req),
        .lastGnt (lastGnt),
        .winner  (winner)
    );

    // Winner is one-hot, so bit 1 is the requester index.
    assign winnerId = winner[1];

`ifdef CACHE_ARB_RR_EN
    logic lastGntNext;

    // Reset value 1 lets requester 0 win the first tie.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lastGnt <= 1'b1;
        end else begin
            lastGnt <= lastGntNext;
        end
    end
`else
    assign lastGnt = 1'b1;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= stateNext;
        end
    end

    // Outputs are produced one state ahead: the values computed on the
    // IDLE->ISSUE transition are what is visible during ISSUE, and so on.
    always_comb begin
        stateNext    = state;
        ownerNext    = owner;
        ownerWeNext  = ownerWe;
        settleNext   = settleCnt;
        gntNext      = 2'b00;
        rspValidNext = 2'b00;
        rspRdataNext = rsp_rdata;
        addrNext     = cache_addr;
        wdataNext    = cache_wdata;
        rdNext       = 1'b0;
        wrNext       = 1'b0;
`ifdef CACHE_ARB_RR_EN
        lastGntNext  = lastGnt;
`endif
        case (state)
            S_IDLE: begin
                if (|req) begin
                    stateNext   = S_ISSUE;
                    ownerNext   = winnerId;
                    ownerWeNext = req_we[winnerId];
                    addrNext    = winnerId ? req_addr[AW +: AW] : req_addr[0 +: AW];
                    wdataNext   = winnerId ? req_wdata[W +: W] : req_wdata[0 +: W];
                    gntNext     = winner;
                    rdNext      = !req_we[winnerId];
                    wrNext      = req_we[winnerId];
`ifdef CACHE_ARB_RR_EN
                    lastGntNext = winnerId;
`endif
                end
            end
            S_ISSUE: begin
                stateNext  = S_WAIT;
                settleNext = SETTLE_W'(SETTLE_CYC);
            end
            S_WAIT: begin
                // The cache raises stall a cycle or so after the strobe; the
                // settle window keeps us from mistaking that gap for a hit.
                if (settleCnt != '0) begin
                    settleNext = settleCnt - SETTLE_W'(1);
                end else if (!cache_stall) begin
                    stateNext           = S_IDLE;
                    rspValidNext[owner] = 1'b1;
                    if (!ownerWe) begin
                        rspRdataNext = cache_rdata;
                    end
                end
            end
            default: begin
                stateNext = S_IDLE;
            end
        endcase
        busyNext = (stateNext != S_IDLE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            owner       <= '0;
            ownerWe     <= 1'b0;
            settleCnt   <= '0;
            gnt         <= 2'b00;
            rsp_valid   <= 2'b00;
            rsp_rdata   <= '0;
            busy        <= 1'b0;
            cache_addr  <= '0;
            cache_wdata <= '0;
            cache_rd    <= 1'b0;
            cache_wr    <= 1'b0;
        end else begin
            owner       <= ownerNext;
            ownerWe     <= ownerWeNext;
            settleCnt   <= settleNext;
            gnt         <= gntNext;
            rsp_valid   <= rspValidNext;
            rsp_rdata   <= rspRdataNext;
            busy        <= busyNext;
            cache_addr  <= addrNext;
            cache_wdata <= wdataNext;
            cache_rd    <= rdNext;
            cache_wr    <= wrNext;
        end
    end

endmodule

// File: tb/tb_cache_port_arbiter.sv
// tb_cache_port_arbiter: bench for cache_port_arbiter with a behavioural cache
// stub (main memory preloaded with RAM[a]=a, random miss lengths) and a
// transaction-level reference model of the arbiter.
module tb_cache_port_arbiter;

    localparam int AW         = 10;
    localparam int W          = 32;
    localparam int SETTLE_CYC = 1;
    localparam int DEPTH      = 1 << AW;

    logic            clk;
    logic            reset;
    logic [1:0]      req;
    logic [1:0]      req_we;
    logic [2*AW-1:0] req_addr;
    logic [2*W-1:0]  req_wdata;
    logic [1:0]      gnt;
    logic [1:0]      rsp_valid;
    logic [W-1:0]    rsp_rdata;
    logic            busy;
    logic [AW-1:0]   cache_addr;
    logic [W-1:0]    cache_wdata;
    logic            cache_rd;
    logic            cache_wr;
    logic            cache_stall;
    logic [W-1:0]    cache_rdata;

    cache_port_arbiter #(.AW(AW), .W(W), .SETTLE_CYC(SETTLE_CYC)) dut (
        .clk         (clk),
        .reset       (reset),
        .req         (req),
        .req_we      (req_we),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .gnt         (gnt),
        .rsp_valid   (rsp_valid),
        .rsp_rdata   (rsp_rdata),
        .busy        (busy),
        .cache_addr  (cache_addr),
        .cache_wdata (cache_wdata),
        .cache_rd    (cache_rd),
        .cache_wr    (cache_wr),
        .cache_stall (cache_stall),
        .cache_rdata (cache_rdata)
    );

    // ---------------- clock ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- checking ----------------
    int checkCnt = 0;
    int errCnt   = 0;

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checkCnt++;
        if (got !== exp) begin
            errCnt++;
            if (errCnt <= 40) $display("FAIL %s got=0x%0h exp=0x%0h @%0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- cache stub ----------------
    logic [W-1:0]  stubMem [DEPTH];
    bit            stubCached [DEPTH];
    int            forceMiss;
    bit            pendValid;
    logic [AW-1:0] pendAddr;
    int            pendLen;

    // Driven on the falling edge. The stall level during the strobe cycle is
    // random (must be ignored); after that stall stays high pendLen cycles
    // with junk data, then drops together with valid read data.
    initial begin
        pendValid   = 1'b0;
        pendLen     = 0;
        pendAddr    = '0;
        cache_stall = 1'b0;
        cache_rdata = '0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                pendValid   = 1'b0;
                cache_stall = 1'b0;
                continue;
            end
            if (pendValid) begin
                if (pendLen > 0) begin
                    cache_stall = 1'b1;
                    cache_rdata = $urandom;
                    pendLen--;
                end else begin
                    cache_stall = 1'b0;
                    cache_rdata = stubMem[pendAddr];
                    pendValid   = 1'b0;
                end
            end
            if (cache_rd || cache_wr) begin
                pendValid = 1'b1;
                pendAddr  = cache_addr;
                if (cache_wr) begin
                    stubMem[cache_addr] = cache_wdata;
                    pendLen = $urandom_range(0, 3);
                end else if (stubCached[cache_addr]) begin
                    pendLen = 0;
                end else begin
                    pendLen = (forceMiss > 0) ? forceMiss : $urandom_range(2, 5);
                    stubCached[cache_addr] = 1'b1;
                end
                cache_stall = 1'($urandom_range(0, 1));
                cache_rdata = $urandom;
            end
        end
    end

    // ---------------- reference model + per-cycle scoreboard ----------------
    // Transaction view: a request seen while no transaction is open is
    // accepted at that edge (cycle a); gnt and exactly one strobe follow it;
    // completion is the first edge at or after a+2+SETTLE_CYC with stall low.
    logic [W-1:0]  refMem [DEPTH];
    int            cyc;
    bit            mActive;
    int            mOwner;
    bit            mWe;
    logic [AW-1:0] mAddr;
    int            mAccCyc;
    int            mLastGnt;
    logic [1:0]    expGnt, expRspV;
    logic          expRd, expWr, expBusy;
    logic [AW-1:0] expAddr;
    logic [W-1:0]  expWdata, expRdata;

    task automatic modelReset();
        mActive  = 1'b0;
        mLastGnt = 1;
        expGnt   = 2'b00;
        expRspV  = 2'b00;
        expRd    = 1'b0;
        expWr    = 1'b0;
        expBusy  = 1'b0;
        expAddr  = '0;
        expWdata = '0;
        expRdata = '0;
    endtask

    initial begin
        int w;
        cyc = 0;
        modelReset();
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (!reset) begin
                modelReset();
            end else begin
                expGnt  = 2'b00;
                expRspV = 2'b00;
                expRd   = 1'b0;
                expWr   = 1'b0;
                if (mActive) begin
                    if (cyc >= mAccCyc + 2 + SETTLE_CYC && !cache_stall) begin
                        expRspV[mOwner] = 1'b1;
                        if (!mWe) expRdata = refMem[mAddr];
                        mActive = 1'b0;
                    end
                end else if (req != 2'b00) begin
                    if (req == 2'b11) begin
`ifdef CACHE_ARB_RR_EN
                        w = (mLastGnt == 0) ? 1 : 0;
`else
                        w = 0;
`endif
                    end else begin
                        w = req[0] ? 0 : 1;
                    end
                    mActive  = 1'b1;
                    mOwner   = w;
                    mWe      = req_we[w];
                    mAddr    = req_addr[w*AW +: AW];
                    mAccCyc  = cyc;
                    mLastGnt = w;
                    expAddr  = mAddr;
                    expWdata = req_wdata[w*W +: W];
                    expGnt[w] = 1'b1;
                    if (mWe) begin
                        expWr = 1'b1;
                        refMem[mAddr] = expWdata;
                    end else begin
                        expRd = 1'b1;
                    end
                end
                expBusy = mActive;
            end
            checkVal("gnt", 32'(gnt), 32'(expGnt));
            checkVal("rsp_valid", 32'(rsp_valid), 32'(expRspV));
            checkVal("rsp_rdata", rsp_rdata, expRdata);
            checkVal("busy", 32'(busy), 32'(expBusy));
            checkVal("cache_addr", 32'(cache_addr), 32'(expAddr));
            checkVal("cache_wdata", cache_wdata, expWdata);
            checkVal("cache_rd", 32'(cache_rd), 32'(expRd));
            checkVal("cache_wr", 32'(cache_wr), 32'(expWr));
        end
    end

    // ---------------- driver tasks ----------------
    int           gntOrder[$];
    int           gntAt[$];
    int           rspAt[$];
    logic [W-1:0] rsp0[$];
    logic [W-1:0] rsp1[$];

    task automatic setReq(input int id, input logic we, input logic [AW-1:0] addr, input logic [W-1:0] wdata);
        req_we[id]            = we;
        req_addr[id*AW +: AW] = addr;
        req_wdata[id*W +: W]  = wdata;
        req[id]               = 1'b1;
    endtask

    // Call at a falling edge with requests set. holdGnts==0: each requester
    // drops its req after its gnt. holdGnts>0: both stay up until that many
    // grants have been seen. Records grant order and response data/cycles.
    task automatic serve(input int holdGnts);
        int  t;
        int  nG;
        bit  done;
        t = 0;
        nG = 0;
        done = 1'b0;
        gntOrder.delete();
        gntAt.delete();
        rspAt.delete();
        rsp0.delete();
        rsp1.delete();
        while (!done && t < 300) begin
            @(posedge clk);
            #1;
            t++;
            for (int i = 0; i < 2; i++) begin
                if (gnt[i]) begin
                    gntOrder.push_back(i);
                    gntAt.push_back(t);
                    nG++;
                end
                if (rsp_valid[i]) begin
                    rspAt.push_back(t);
                    if (i == 0) rsp0.push_back(rsp_rdata);
                    else        rsp1.push_back(rsp_rdata);
                end
            end
            if (req == 2'b00 && !busy) done = 1'b1;
            @(negedge clk);
            if (holdGnts == 0)        req = req & ~gnt;
            else if (nG >= holdGnts) req = 2'b00;
        end
        checkVal("serve_timeout", 32'(done), 32'd1);
    endtask

    task automatic doReset();
        reset = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int  expOrder[4];
        bit  gotGnt;
        reset     = 1'b0;
        req       = 2'b00;
        req_we    = 2'b00;
        req_addr  = '0;
        req_wdata = '0;
        forceMiss = 0;
        for (int a = 0; a < DEPTH; a++) begin
            stubMem[a]    = W'(a);
            refMem[a]     = W'(a);
            stubCached[a] = 1'b0;
        end
        repeat (3) @(negedge clk);
        checkVal("rst_busy", 32'(busy), 32'd0);
        checkVal("rst_gnt", 32'(gnt), 32'd0);
        reset = 1'b1;

        // Single write to 0x000.
        setReq(0, 1'b1, 10'h000, 32'h5);
        serve(0);
        checkVal("wr_ngnt", gntOrder.size(), 1);
        checkVal("wr_gnt_at", gntAt.size() > 0 ? gntAt[0] : -1, 1);
        checkVal("wr_nrsp", rsp0.size(), 1);
        checkVal("wr_ram0", stubMem[0], 32'h5);

        // Simultaneous reads straight after reset.
        doReset();
        setReq(0, 1'b0, 10'h020, $urandom);
        setReq(1, 1'b0, 10'h040, $urandom);
        serve(0);
        checkVal("sim_ngnt", gntOrder.size(), 2);
        checkVal("sim_first", gntOrder.size() > 0 ? gntOrder[0] : -1, 0);
        checkVal("sim_second", gntOrder.size() > 1 ? gntOrder[1] : -1, 1);
        checkVal("sim_rd0", rsp0.size() > 0 ? rsp0[0] : 32'hdead, 32'h20);
        checkVal("sim_rd1", rsp1.size() > 0 ? rsp1[0] : 32'hdead, 32'h40);

        // Fairness with both requests held through four grants.
`ifdef CACHE_ARB_RR_EN
        expOrder = '{0, 1, 0, 1};
`else
        expOrder = '{0, 0, 0, 0};
`endif
        setReq(0, 1'b0, 10'h020, $urandom);
        setReq(1, 1'b0, 10'h040, $urandom);
        serve(4);
        checkVal("fair_ngnt", gntOrder.size(), 4);
        for (int i = 0; i < 4; i++) begin
            checkVal($sformatf("fair_order%0d", i), gntOrder.size() > i ? gntOrder[i] : -1, expOrder[i]);
        end
        checkVal("fair_nrsp", rspAt.size(), 4);

        // Hit timing: 0x020 is cached now.
        setReq(1, 1'b0, 10'h020, $urandom);
        serve(0);
        checkVal("hit_gnt_at", gntAt.size() > 0 ? gntAt[0] : -1, 1);
        checkVal("hit_rsp_at", rspAt.size() > 0 ? rspAt[0] : -1, 4);
        checkVal("hit_rdata", rsp1.size() > 0 ? rsp1[0] : 32'hdead, 32'h20);

        // Miss on 0x3ff: address held during stall (scoreboard), data after.
        setReq(0, 1'b0, 10'h3ff, $urandom);
        serve(0);
        checkVal("miss_rdata", rsp0.size() > 0 ? rsp0[0] : 32'hdead, 32'h3ff);
        checkVal("miss_slow", 32'(rspAt.size() > 0 && rspAt[0] >= 5), 32'd1);

        // Reset in the middle of a miss on 0x060.
        forceMiss = 4;
        setReq(0, 1'b0, 10'h060, $urandom);
        gotGnt = 1'b0;
        for (int k = 0; k < 20 && !gotGnt; k++) begin
            @(posedge clk);
            #1;
            gotGnt = gnt[0];
        end
        checkVal("rstmid_gnt", 32'(gotGnt), 32'd1);
        @(negedge clk);
        req = 2'b00;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkVal("rstmid_busy_pre", 32'(busy), 32'd1);
        reset = 1'b0;
        #1;
        checkVal("rstmid_gnt0", 32'(gnt), 32'd0);
        checkVal("rstmid_rsp0", 32'(rsp_valid), 32'd0);
        checkVal("rstmid_rdata0", rsp_rdata, 32'd0);
        checkVal("rstmid_busy0", 32'(busy), 32'd0);
        checkVal("rstmid_addr0", 32'(cache_addr), 32'd0);
        checkVal("rstmid_wdata0", cache_wdata, 32'd0);
        checkVal("rstmid_strobes", 32'({cache_rd, cache_wr}), 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        forceMiss = 0;
        setReq(0, 1'b0, 10'h060, $urandom);
        serve(0);
        checkVal("rstmid_retry", rsp0.size() > 0 ? rsp0[0] : 32'hdead, 32'h60);

        // Random traffic, with some requests withdrawn before grant.
        for (int c = 0; c < 800; c++) begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                if (req[i] && gnt[i]) begin
                    req[i] = 1'b0;
                end else if (req[i] && $urandom_range(0, 15) == 0) begin
                    req[i] = 1'b0;
                end else if (!req[i] && $urandom_range(0, 2) == 0) begin
                    setReq(i, 1'($urandom_range(0, 1)),
                           $urandom_range(0, 1) ? AW'($urandom_range(0, 15)) : AW'($urandom_range(0, DEPTH - 1)),
                           $urandom);
                end
            end
        end
        @(negedge clk);
        req = 2'b00;
        for (int k = 0; k < 60 && busy; k++) @(negedge clk);
        checkVal("drain_busy", 32'(busy), 32'd0);

        for (int a = 0; a < DEPTH; a++) begin
            checkVal("mem", stubMem[a], refMem[a]);
        end

        $display("CHECKS %0d ERRORS %0d", checkCnt, errCnt);
        $finish;
    end

endmodule

// File: doc/cache_port_arbiter.md
Name: cache_port_arbiter

Overview:
- Two-requester arbiter and sequencer placed in front of the write-through caching system (10-bit word address, 32-bit data, mem_read/mem_write strobes, stall, DataOut).
- Accepts one request at a time and drives a single-cycle read or write strobe into the cache.
- Holds the cache address and write data stable until the cache stops stalling, then returns completion and read data to the owning requester.
- Typical use: instruction port (requester 0) and data port (requester 1) share one cache.

Parameters:
- AW, 10, word-address width
- W, 32, data width
- SETTLE_CYC, 1, WAIT cycles after the strobe during which stall is ignored (covers the cache's stall-rise latency); legal values are 1 to 3

Ports:
- clk  in  1  clock; rising edge
- reset  in  1  asynchronous, active-low reset
- req  in  2  request per requester; held until gnt
- req_we  in  2  1 = write, 0 = read, per requester
- req_addr  in  2*AW  requester i address at [i*AW +: AW]
- req_wdata  in  2*W  requester i write data at [i*W +: W]
- gnt  out  2  one-cycle pulse: request accepted
- rsp_valid  out  2  one-cycle pulse: transaction complete
- rsp_rdata  out  W  read data; valid while rsp_valid is high
- busy  out  1  high when state is not IDLE
- cache_addr  out  AW  to WordAddress
- cache_wdata  out  W  to DataIn
- cache_rd  out  1  to mem_read
- cache_wr  out  1  to mem_write
- cache_stall  in  1  from stall
- cache_rdata  in  W  from DataOut

Behaviour:
- All outputs are registered. Under reset every output is 0, state is IDLE, and the round-robin pointer last_gnt is 1, so requester 0 wins first.
- Reset is asynchronous. Asserting it mid-transaction abandons the transaction: the strobe drops immediately and no rsp_valid is issued. Any cache refill already in progress finishes inside the cache.
- FSM states: IDLE, ISSUE, WAIT.
- IDLE:
  - If any req bit is set at edge N, select the winner and latch its we, addr and wdata into cache_wdata and cache_addr, then go to ISSUE.
  - With both requesting, the winner is the requester that is not last_gnt; update last_gnt to the winner.
- ISSUE (cycle N+1):
  - Drive gnt[winner]=1.
  - Drive cache_rd = !we or cache_wr = we; exactly one strobe, for exactly one cycle.
  - Load settle_cnt with SETTLE_CYC, then go to WAIT.
- WAIT:
  - Strobes are low; cache_addr and cache_wdata are held.
  - While settle_cnt > 0, decrement it and ignore cache_stall.
  - Once settle_cnt = 0, the first cycle with cache_stall=0 completes the transaction. On that edge: rsp_valid[owner]=1; rsp_rdata = cache_rdata for a read, or holds its previous value for a write; go to IDLE.
- Latency with SETTLE_CYC=1 and no stall:
  - gnt in cycle N+1
  - rsp_valid in cycle N+4
  - A miss adds one cycle per stall-high cycle.
- Back-to-back: IDLE may sample a new req in the same cycle rsp_valid is high. A new strobe is issued at N+5 at the earliest.
- A req dropped before gnt is simply not served. req changes during ISSUE or WAIT are ignored.
- cache_addr and cache_wdata hold their last values in IDLE, with no glitch toward the cache.
- No requester can receive gnt while another transaction is in ISSUE or WAIT.

Optional Feature:
- CACHE_ARB_RR_EN defined: round-robin arbitration via last_gnt, as described above.
- CACHE_ARB_RR_EN undefined: fixed priority, requester 0 always wins; last_gnt is not implemented and requester 1 may starve.
- FSM, timing and ports are identical in both builds.

Decomposition:
- Shared package/include cache_arb_pkg:
  - state encoding constants S_IDLE=2'd0, S_ISSUE=2'd1, S_WAIT=2'd2
  - AW/W defaults
  - requester-ID width (1)
- One natural sub-module: rr_pick2, a combinational 2-way picker taking req[1:0] and last_gnt and returning a one-hot winner; fixed-priority variant under the macro.
- The FSM stays in the top level.

Test Plan (main memory preloaded with RAM[a]=a; reset released before stimulus):
- Single write: req[0] write addr 0x000 data 0x5 -> gnt[0] at N+1; cache_wr high exactly one cycle with cache_addr=0x000 and cache_wdata=0x5; rsp_valid[0] after stall falls; RAM[0x000]==0x5.
- Simultaneous reads after reset: req0 addr 0x020 and req1 addr 0x040 at the same edge -> gnt[0] first, rsp_valid[0] with rsp_rdata=0x20; then gnt[1], rsp_valid[1] with rsp_rdata=0x40.
- Fairness (CACHE_ARB_RR_EN): both req held through 4 transactions -> grant order 0,1,0,1; without the macro the order is 0,0,0,0.
- Hit timing: re-read 0x020 via req1 -> gnt[1] at N+1, rsp_valid[1] at N+4, rdata 0x20, busy high for N+1..N+3.
- Miss hold: read 0x3ff -> cache_addr stays 0x3ff for every stall-high cycle; rsp_rdata=0x3ff one cycle after stall falls.
- Reset mid-miss: reset low during WAIT of read 0x060 -> all outputs 0 at once, no rsp_valid. After release, the same request returns 0x60.
